shift_reg_param: RTL and testbench
==================================

// Module: shift_reg_param
// PURPOSE
//   Parametrised WIDTH-bit register, successor to the single-bit D flip-flop.
//   Per-cycle ops: hold, load, shift, rotate, arithmetic shift, clear.
//   A start/amount handshake runs a multi-step shift/rotate autonomously.
//   Used as the datapath register for the serial, shifter and counter labs.
// PARAMETERS
//   WIDTH      8    register width in bits, >= 2
//   CNT_W      4    width of amount; shift counts 0 .. 2^CNT_W-1
//   RESET_VAL  0    WIDTH-bit value loaded by rst and by op CLR
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   op         in   3      0 HOLD,1 LOAD,2 SHL,3 SHR,4 ROL,5 ROR,6 ASR,7 CLR
//   start      in   1      request multi-step op (sampled only when not busy)
//   amount     in   CNT_W  number of steps for start
//   D          in   WIDTH  parallel load data
//   ser_in_l   in   1      fill bit entering MSB on SHR
//   ser_in_r   in   1      fill bit entering LSB on SHL
//   Q          out  WIDTH  register contents
//   Q_bar      out  WIDTH  always ~Q
//   ser_out_l  out  1      Q[WIDTH-1]
//   ser_out_r  out  1      Q[0]
//   busy       out  1      multi-step op in progress
//   done       out  1      one-cycle pulse: multi-step op complete
// BEHAVIOUR
//   Reset (rst=1, asynchronous): Q=RESET_VAL, Q_bar=~RESET_VAL, busy=0, done=0,
//     FSM=IDLE, step counter=0. Takes effect immediately, not at an edge.
//   Step functions (one edge):
//     SHL {Q[W-2:0],ser_in_r}; SHR {ser_in_l,Q[W-1:1]}; ROL {Q[W-2:0],Q[W-1]};
//     ROR {Q[0],Q[W-1:1]}; ASR {Q[W-1],Q[W-1:1]}; LOAD D; CLR RESET_VAL; HOLD Q.
//   FSM states: IDLE, SHIFT.
//   IDLE, start=0: apply op at every edge. LOAD gives a D-FF with 1-edge latency.
//   IDLE, start=1, op in SHL..ASR, amount=N>0:
//     - latch op, then apply the first step at this edge k.
//     - N=1: stay IDLE; done=1 for the next cycle.
//     - N>1: go to SHIFT, busy=1, counter=N-1.
//   SHIFT: apply the latched op at every edge and decrement the counter.
//     - Last step (counter==1): go to IDLE, busy=0, done=1.
//     - Result: N steps on edges k..k+N-1; busy high N-1 cycles; done high
//       for the one cycle after edge k+N-1.
//   SHIFT ignores op, start, amount and D. ser_in_l/ser_in_r are sampled live at
//     every step.
//   start with amount=0, or with op HOLD/LOAD/CLR: apply op once (HOLD = no
//     change); done=1 the next cycle; no SHIFT entry.
//   done deasserts at the next edge unless a new start completes at that edge.
//   start and done may be high together, allowing back-to-back requests.
//   amount > WIDTH is legal: steps continue. ROL/ROR by WIDTH restores Q;
//     SHL by >= WIDTH gives all ser_in_r.
//   rst during SHIFT aborts: no done pulse, partial result discarded.
//   Q_bar, ser_out_l and ser_out_r are combinational from Q; they never
//     disagree with Q.
// STRUCTURE
//   Package shift_reg_pkg holds:
//     - op encodings as localparams OP_HOLD..OP_CLR
//     - FSM state encodings ST_IDLE, ST_SHIFT
//   Sub-module shift_reg_step (combinational): op, Q, ser_in_l, ser_in_r, D ->
//     next Q. Shared by the IDLE and SHIFT paths.
//   Top level: FSM, step counter, Q register, done/busy registers.
// TESTING (WIDTH=8, CNT_W=4, RESET_VAL=0)
//   1. Assert rst between edges with Q=0x5A -> Q=0x00, Q_bar=0xFF
//      before the next edge; busy=0, done=0.
//   2. start=0, op=LOAD, D toggles 0x00/0xFF every 10 ns -> Q follows D one
//      edge later, Q_bar its inverse.
//   3. LOAD 0x81, then start ROL amount=3 -> Q=0x0C three edges later;
//      busy high 2 cycles; done high exactly 1 cycle.
//   4. LOAD 0x80: ASR amount=3 -> 0xF0. LOAD 0x80: SHR amount=3 with
//      ser_in_l=0 -> 0x10. LOAD 0x01: SHL amount=2 with ser_in_r=1 -> 0x07.
//   5. LOAD 0xA5: ROL amount=8 -> 0xA5, done after 8 edges. Then start with
//      amount=0 -> Q unchanged, done next cycle.
//   6. start SHL amount=5, toggle op/D while busy -> ignored. Assert rst after
//      2 steps -> Q=0x00, busy=0, no done pulse.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the parametrised shift register.
// Op codes, FSM states and an op classifier.
package shift_reg_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd2;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd3;
  localparam logic [OP_W-1:0] OP_ROL  = 3'd4;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd5;
  localparam logic [OP_W-1:0] OP_ASR  = 3'd6;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_op(
    input logic [OP_W-1:0] op
  );
    return (op >= OP_SHL) && (op <= OP_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_if.sv
// Control/data bundle for shift_reg_param.
// master drives requests, slave is the register.
interface shift_reg_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic [OP_W-1:0]  op;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] D;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  modport master (
    output op, start, amount, D,
    output ser_in_l, ser_in_r,
    input  Q, Q_bar,
    input  ser_out_l, ser_out_r,
    input  busy, done
  );

  modport slave (
    input  op, start, amount, D,
    input  ser_in_l, ser_in_r,
    output Q, Q_bar,
    output ser_out_l, ser_out_r,
    output busy, done
  );

endinterface

// File: rtl/shift_reg_step.sv
// Single-step next-value function of the register.
// Shared by the per-cycle and multi-step paths.
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_HOLD: q_next = q;
      OP_LOAD: q_next = d;
      OP_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
      OP_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLR:  q_next = RESET_VAL;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_param.sv
// WIDTH-bit register with per-cycle ops and an
// autonomous multi-step shift/rotate sequencer.
module shift_reg_param
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  shift_reg_if.slave bus
);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_lat_q, op_lat_d;
  logic [OP_W-1:0]  step_op;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             multi;
  logic             last;

  assign multi = bus.start
              && is_shift_op(bus.op)
              && (bus.amount > CNT_W'(1));
  assign last  = (cnt_q == CNT_W'(1));

  shift_reg_step #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_step (
    .op       (step_op),
    .q        (q_q),
    .d        (bus.D),
    .ser_in_l (bus.ser_in_l),
    .ser_in_r (bus.ser_in_r),
    .q_next   (q_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (multi) state_d = ST_SHIFT;
      ST_SHIFT: if (last)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // First step happens on the accepting edge, so SHIFT owns N-1 steps.
  always_comb begin
    step_op  = bus.op;
    op_lat_d = op_lat_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (multi) begin
          op_lat_d = bus.op;
          cnt_d    = bus.amount - CNT_W'(1);
        end else if (bus.start) begin
          done_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        step_op = op_lat_q;
        cnt_d   = cnt_q - CNT_W'(1);
        done_d  = last;
      end
      default: ;
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= RESET_VAL;
      op_lat_q <= OP_HOLD;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      op_lat_q <= op_lat_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Q         = q_q;
  assign bus.Q_bar     = ~q_q;
  assign bus.ser_out_l = q_q[WIDTH-1];
  assign bus.ser_out_r = q_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// Directed self-checking bench for shift_reg_param.
// WIDTH=8, CNT_W=4, RESET_VAL=0.
module tb_shift_reg_param;
  import shift_reg_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shift_reg_param #(
    .WIDTH     (8),
    .CNT_W     (4),
    .RESET_VAL (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.op    = OP_LOAD;
    bus.start = 1'b0;
    bus.D     = v;
    tick();
    bus.op    = OP_HOLD;
  endtask

  // Issues a start and observes until done; returns what it saw.
  task automatic run_op(
    input  logic [2:0] op,
    input  logic [3:0] amt,
    output int         edges,
    output int         busy_cnt,
    output int         done_cnt,
    output logic [7:0] q_res,
    output logic       timeout
  );
    bus.op     = op;
    bus.amount = amt;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.op     = OP_HOLD;
    edges      = 1;
    busy_cnt   = 0;
    done_cnt   = 0;
    timeout    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        timeout = 1'b0;
        break;
      end
      tick();
      edges++;
    end
    q_res = bus.Q;
    tick();
    if (bus.done) done_cnt++;
  endtask

  task automatic test_reset();
    if (bus.Q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset_init Q=%h busy=%b done=%b want 00/0/0",
               bus.Q, bus.busy, bus.done);
      failures++;
    end
    checks++;
    load(8'h5A);
    if (bus.Q !== 8'h5A) begin
      $display("FAIL reset_preload Q=%h want 5a", bus.Q);
      failures++;
    end
    checks++;
    #3 rst = 1'b1;
    #1;
    if (bus.Q !== 8'h00 || bus.Q_bar !== 8'hFF) begin
      $display("FAIL reset_async Q=%h Q_bar=%h want 00/ff",
               bus.Q, bus.Q_bar);
      failures++;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset_flags busy=%b done=%b want 0/0",
               bus.busy, bus.done);
      failures++;
    end
    checks++;
    #1 rst = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v = (i % 2 == 0) ? 8'hFF : 8'h00;
      bus.D  = v;
      bus.op = OP_LOAD;
      if (i > 0 && bus.Q !== ~v) begin
        $display("FAIL load_latency i=%0d Q=%h want %h", i, bus.Q, ~v);
        failures++;
      end
      if (i > 0) checks++;
      tick();
      if (bus.Q !== v || bus.Q_bar !== ~v) begin
        $display("FAIL load i=%0d Q=%h Q_bar=%h want %h/%h",
                 i, bus.Q, bus.Q_bar, v, ~v);
        failures++;
      end
      checks++;
      if (bus.ser_out_l !== v[7] || bus.ser_out_r !== v[0]) begin
        $display("FAIL ser_out i=%0d l=%b r=%b want %b/%b",
                 i, bus.ser_out_l, bus.ser_out_r, v[7], v[0]);
        failures++;
      end
      checks++;
    end
    bus.op = OP_HOLD;
  endtask

  task automatic test_rol3();
    int e, b, d;
    logic [7:0] q;
    logic to;
    load(8'h81);
    run_op(OP_ROL, 4'd3, e, b, d, q, to);
    if (to || q !== 8'h0C || e !== 3) begin
      $display("FAIL rol3 Q=%h edges=%0d to=%b want 0c/3/0", q, e, to);
      failures++;
    end
    checks++;
    if (b !== 2 || d !== 1) begin
      $display("FAIL rol3_flags busy=%0d done=%0d want 2/1", b, d);
      failures++;
    end
    checks++;
  endtask

  task automatic test_shifts();
    int e, b, d;
    logic [7:0] q;
    logic to;
    load(8'h80);
    run_op(OP_ASR, 4'd3, e, b, d, q, to);
    if (to || q !== 8'hF0 || e !== 3) begin
      $display("FAIL asr3 Q=%h edges=%0d want f0/3", q, e);
      failures++;
    end
    checks++;
    load(8'h80);
    bus.ser_in_l = 1'b0;
    run_op(OP_SHR, 4'd3, e, b, d, q, to);
    if (to || q !== 8'h10 || e !== 3) begin
      $display("FAIL shr3 Q=%h edges=%0d want 10/3", q, e);
      failures++;
    end
    checks++;
    load(8'h01);
    bus.ser_in_r = 1'b1;
    run_op(OP_SHL, 4'd2, e, b, d, q, to);
    if (to || q !== 8'h07 || e !== 2 || b !== 1) begin
      $display("FAIL shl2 Q=%h edges=%0d busy=%0d want 07/2/1",
               q, e, b);
      failures++;
    end
    checks++;
    load(8'h00);
    run_op(OP_SHL, 4'd10, e, b, d, q, to);
    if (to || q !== 8'hFF || e !== 10) begin
      $display("FAIL shl10 Q=%h edges=%0d want ff/10", q, e);
      failures++;
    end
    checks++;
    bus.ser_in_r = 1'b0;
  endtask

  task automatic test_rol_width();
    int e, b, d;
    logic [7:0] q;
    logic to;
    load(8'hA5);
    run_op(OP_ROL, 4'd8, e, b, d, q, to);
    if (to || q !== 8'hA5 || e !== 8 || b !== 7 || d !== 1) begin
      $display("FAIL rol8 Q=%h edges=%0d busy=%0d done=%0d want a5/8/7/1",
               q, e, b, d);
      failures++;
    end
    checks++;
    run_op(OP_HOLD, 4'd0, e, b, d, q, to);
    if (to || q !== 8'hA5 || e !== 1 || b !== 0) begin
      $display("FAIL amt0 Q=%h edges=%0d busy=%0d want a5/1/0",
               q, e, b);
      failures++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    bus.op     = OP_ROL;
    bus.amount = 4'd1;
    bus.start  = 1'b1;
    tick();
    if (bus.Q !== 8'h02 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL b2b_first Q=%h done=%b busy=%b want 02/1/0",
               bus.Q, bus.done, bus.busy);
      failures++;
    end
    checks++;
    bus.amount = 4'd2;
    tick();
    bus.start  = 1'b0;
    bus.op     = OP_HOLD;
    if (bus.Q !== 8'h04 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL b2b_second Q=%h done=%b busy=%b want 04/0/1",
               bus.Q, bus.done, bus.busy);
      failures++;
    end
    checks++;
    tick();
    if (bus.Q !== 8'h08 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL b2b_end Q=%h done=%b busy=%b want 08/1/0",
               bus.Q, bus.done, bus.busy);
      failures++;
    end
    checks++;
    tick();
  endtask

  task automatic test_abort();
    int dseen;
    load(8'h01);
    bus.ser_in_r = 1'b1;
    bus.op       = OP_SHL;
    bus.amount   = 4'd5;
    bus.start    = 1'b1;
    tick();
    bus.op     = OP_LOAD;
    bus.D      = 8'hAA;
    bus.amount = 4'd1;
    tick();
    if (bus.Q !== 8'h07 || bus.busy !== 1'b1) begin
      $display("FAIL busy_ignore Q=%h busy=%b want 07/1",
               bus.Q, bus.busy);
      failures++;
    end
    checks++;
    bus.start = 1'b0;
    bus.op    = OP_HOLD;
    #3 rst = 1'b1;
    #1;
    if (bus.Q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL abort Q=%h busy=%b done=%b want 00/0/0",
               bus.Q, bus.busy, bus.done);
      failures++;
    end
    checks++;
    #1 rst = 1'b0;
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.busy) dseen++;
    end
    if (dseen !== 0 || bus.Q !== 8'h00) begin
      $display("FAIL abort_after flags=%0d Q=%h want 0/00",
               dseen, bus.Q);
      failures++;
    end
    checks++;
    bus.ser_in_r = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.op       = OP_HOLD;
    bus.start    = 1'b0;
    bus.amount   = 4'd0;
    bus.D        = 8'h00;
    bus.ser_in_l = 1'b0;
    bus.ser_in_r = 1'b0;
    #12 rst = 1'b0;
    tick();
    test_reset();
    test_load();
    test_rol3();
    test_shifts();
    test_rol_width();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
